// File: rtl/req_fifo_decoder.sv
// req_fifo_decoder: turns active-low device requests into 3-bit indices and queues them in arrival order.
// A device is queued once per assertion; it must release its line before it can be queued again.
module req_fifo_decoder #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_n,
    input  logic       pop,
    output logic [2:0] idx_out,
    output logic       valid,
    output logic       full,
    output logic [7:0] queued
);
    logic [2:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd, r_wr;
    logic [PTR_W:0]   r_count;
    logic [7:0]       r_queued, r_armed;
    logic [2:0]       r_last;
    logic [7:0]       w_elig, w_set, w_clr;
    logic [2:0]       w_idx;
    logic             w_push, w_pop;
    always_comb begin
        w_elig = ~req_n & ~r_queued & r_armed;
        w_idx  = '0;
        for (int i = 7; i >= 0; i--)
            if (w_elig[i]) w_idx = 3'(i);
        w_push = |w_elig && !full;
        w_pop  = pop && valid;
        w_set  = w_push ? 8'b1 << w_idx : '0;
        w_clr  = w_pop ? 8'b1 << r_mem[r_rd] : '0;
    end
    always_ff @(posedge clk)
        if (rst_n && w_push) r_mem[r_wr] <= w_idx;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd     <= '0;
            r_wr     <= '0;
            r_count  <= '0;
            r_queued <= '0;
            r_armed  <= '1;
            r_last   <= '0;
        end else begin
            r_wr     <= r_wr + PTR_W'(w_push);
            r_rd     <= r_rd + PTR_W'(w_pop);
            r_count  <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
            r_queued <= (r_queued & ~w_clr) | w_set;
            r_armed  <= (r_armed | req_n) & ~w_set;
            // Keeps the last head visible once the queue drains
            if (valid) r_last <= r_mem[r_rd];
        end
    end
    assign valid   = r_count != '0;
    assign full    = r_count == (PTR_W+1)'(DEPTH);
    assign queued  = r_queued;
    assign idx_out = valid ? r_mem[r_rd] : r_last;
endmodule

// File: tb/tb_req_fifo_decoder.sv
// tb_req_fifo_decoder: scenario tasks with an expected-index scoreboard drained through pop.
module tb_req_fifo_decoder;
    logic       clk = 0, rst_n = 0, pop = 0;
    logic [7:0] req_n = 8'hFF;
    logic [2:0] idx_out;
    logic       valid, full;
    logic [7:0] queued;
    int         checks = 0, errors = 0;
    logic [2:0] sb [$];
    logic [2:0] exp_idx;

    req_fifo_decoder #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .req_n(req_n), .pop(pop),
        .idx_out(idx_out), .valid(valid), .full(full), .queued(queued)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; pop = 0; req_n = 8'hFF;
        tick();
        rst_n = 1;
        sb.delete();
    endtask

    task automatic drain(input string name);
        req_n = 8'hFF;
        for (int n = 0; n < 16 && sb.size() > 0; n++) begin
            exp_idx = sb.pop_front();
            checks++;
            if (valid !== 1'b1 || idx_out !== exp_idx) begin
                errors++;
                $display("FAIL %s head: valid=%b idx=%0d, required valid=1 idx=%0d", name, valid, idx_out, exp_idx);
            end
            pop = 1; tick(); pop = 0;
        end
        checks++;
        if (valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL %s empty: valid=%b left=%0d, required valid=0 left=0", name, valid, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 0; pop = 1; req_n = 8'h00;
        tick();
        checks++;
        if (valid !== 0 || full !== 0 || queued !== 8'h00 || idx_out !== 3'd0) begin
            errors++;
            $display("FAIL reset: valid=%b full=%b queued=%h idx=%0d, required 0 0 00 0", valid, full, queued, idx_out);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req_n = 8'hFB;
        tick();
        checks++;
        if (valid !== 1 || idx_out !== 3'd2 || queued !== 8'h04) begin
            errors++;
            $display("FAIL single push: valid=%b idx=%0d queued=%h, required 1 2 04", valid, idx_out, queued);
        end
        tick(3);
        pop = 1; tick(); pop = 0;
        checks++;
        if (valid !== 0 || queued !== 8'h00) begin
            errors++;
            $display("FAIL single once: valid=%b queued=%h, required 0 00", valid, queued);
        end
        tick(2);
        checks++;
        if (valid !== 0 || idx_out !== 3'd2) begin
            errors++;
            $display("FAIL single hold: valid=%b idx=%0d, required 0 2", valid, idx_out);
        end
    endtask

    task automatic test_multi();
        do_reset();
        req_n = 8'h5A;
        sb = '{3'd0, 3'd2, 3'd5, 3'd7};
        tick();
        checks++;
        if (queued !== 8'h01) begin
            errors++;
            $display("FAIL multi first: queued=%h, required 01", queued);
        end
        tick(3);
        checks++;
        if (queued !== 8'hA5) begin
            errors++;
            $display("FAIL multi all: queued=%h, required a5", queued);
        end
        drain("multi");
    endtask

    task automatic test_order();
        do_reset();
        req_n = 8'hBF; tick();
        req_n = 8'hFF; tick();
        req_n = 8'hFD; tick();
        req_n = 8'hF7; tick();
        sb = '{3'd6, 3'd1, 3'd3};
        checks++;
        if (queued !== 8'h4A) begin
            errors++;
            $display("FAIL order queued=%h, required 4a", queued);
        end
        drain("order");
    endtask

    task automatic test_rearm();
        do_reset();
        req_n = 8'hEF; tick();
        pop = 1; tick(); pop = 0;
        tick(2);
        checks++;
        if (valid !== 0 || queued !== 8'h00) begin
            errors++;
            $display("FAIL rearm held: valid=%b queued=%h, required 0 00", valid, queued);
        end
        req_n = 8'hFF; tick();
        req_n = 8'hEF; tick();
        checks++;
        if (valid !== 1 || idx_out !== 3'd4 || queued !== 8'h10) begin
            errors++;
            $display("FAIL rearm requeue: valid=%b idx=%0d queued=%h, required 1 4 10", valid, idx_out, queued);
        end
    endtask

    task automatic test_full();
        do_reset();
        req_n = 8'h00;
        tick(8);
        for (int i = 0; i < 8; i++) sb.push_back(3'(i));
        checks++;
        if (full !== 1 || queued !== 8'hFF || idx_out !== 3'd0) begin
            errors++;
            $display("FAIL full: full=%b queued=%h idx=%0d, required 1 ff 0", full, queued, idx_out);
        end
        req_n = 8'hFF;
        void'(sb.pop_front());
        pop = 1; tick();
        req_n = 8'hFE;
        sb.push_back(3'd0);
        void'(sb.pop_front());
        tick();
        checks++;
        if (full !== 0 || queued !== 8'hFD || idx_out !== 3'd2) begin
            errors++;
            $display("FAIL push+pop: full=%b queued=%h idx=%0d, required 0 fd 2", full, queued, idx_out);
        end
        pop = 0; req_n = 8'hFC;
        sb.push_back(3'd1);
        tick();
        checks++;
        if (full !== 1 || queued !== 8'hFF) begin
            errors++;
            $display("FAIL refill: full=%b queued=%h, required 1 ff", full, queued);
        end
        drain("full");
        pop = 1; tick(2); pop = 0;
        checks++;
        if (valid !== 0 || full !== 0 || queued !== 8'h00 || idx_out !== 3'd1) begin
            errors++;
            $display("FAIL empty pop: valid=%b full=%b queued=%h idx=%0d, required 0 0 00 1", valid, full, queued, idx_out);
        end
        req_n = 8'hDF; tick();
        checks++;
        if (valid !== 1 || idx_out !== 3'd5) begin
            errors++;
            $display("FAIL after empty pop: valid=%b idx=%0d, required 1 5", valid, idx_out);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req_n = 8'hE0;
        tick(5);
        checks++;
        if (queued !== 8'h1F) begin
            errors++;
            $display("FAIL mid fill: queued=%h, required 1f", queued);
        end
        rst_n = 0; tick(); rst_n = 1;
        checks++;
        if (valid !== 0 || full !== 0 || queued !== 8'h00 || idx_out !== 3'd0) begin
            errors++;
            $display("FAIL mid reset: valid=%b full=%b queued=%h idx=%0d, required 0 0 00 0", valid, full, queued, idx_out);
        end
        tick();
        checks++;
        if (valid !== 1 || idx_out !== 3'd0 || queued !== 8'h01) begin
            errors++;
            $display("FAIL mid reenter: valid=%b idx=%0d queued=%h, required 1 0 01", valid, idx_out, queued);
        end
        tick(4);
        sb = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        drain("mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_order();
        test_rearm();
        test_full();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
